// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmitter; start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between the data and stop bits.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter value");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   line_q, line_d;
    logic                   done_q, done_d;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        line_d  = line_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end = (cnt_q == CNT_LAST);
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shreg_d = data_in;
                    line_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^data_in) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    line_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        line_d  = parity_q;
`else
                        state_d = STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        line_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                // bit counter is reused to count stop bits
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            line_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            line_q   <= line_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign data_out   = line_q;
    assign done       = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven, random and hand-written frame checks for uart_tx_frame
// against a bit-list frame model; honours UART_TX_PARITY_EN when compiled with it.
module tb_uart_tx_frame;

    localparam int DB_A = 8, CPB_A = 4, SB_A = 1;
    localparam int DB_B = 5, CPB_B = 3, SB_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int P_EN = 1;
`else
    localparam int P_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din_a = '0;
    logic       dv_a = 1'b0;
    logic [8:0] din_b = '0;
    logic       dv_b = 1'b0;
    logic       rdy_a, line_a, busy_a, done_a;
    logic       rdy_o, line_o, busy_o, done_o;
    logic       rdy_b, line_b, busy_b, done_b;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(DB_A), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A), .PARITY_ODD(0)) dut_a (
        .clk_in(clk), .reset(reset), .data_in(din_a), .data_valid(dv_a),
        .data_ready(rdy_a), .data_out(line_a), .busy(busy_a), .done(done_a));

    uart_tx_frame #(.DATA_BITS(DB_A), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A), .PARITY_ODD(1)) dut_o (
        .clk_in(clk), .reset(reset), .data_in(din_a), .data_valid(dv_a),
        .data_ready(rdy_o), .data_out(line_o), .busy(busy_o), .done(done_o));

    uart_tx_frame #(.DATA_BITS(DB_B), .CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B), .PARITY_ODD(0)) dut_b (
        .clk_in(clk), .reset(reset), .data_in(din_b[DB_B-1:0]), .data_valid(dv_b),
        .data_ready(rdy_b), .data_out(line_b), .busy(busy_b), .done(done_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected line: index k = k-th cycle after the acceptance edge; frame bits each last cpb cycles.
    function automatic logic [127:0] model_line(input int db, input int cpb, input int sb,
                                                input logic [8:0] d, input logic par);
        logic bits[$];
        logic [127:0] v = '1;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(d[i]);
        if (P_EN != 0) bits.push_back(par);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        for (int k = 1; k <= bits.size() * cpb; k++) v[k] = bits[(k - 1) / cpb];
        return v;
    endfunction

    task automatic drive(input int grp, input logic [8:0] d, input logic v);
        if (grp == 0) begin
            din_a = d[7:0];
            dv_a  = v;
        end else begin
            din_b = d;
            dv_b  = v;
        end
    endtask

    // Sends d (accepted at the next posedge) and checks F+1 cycles of every output of the group.
    task automatic run_frame(input int grp, input logic [8:0] d, input logic par_even,
                             input int exp_cycles, input bit noise, input bit chain,
                             input logic [8:0] next_d, input bit preloaded, input string tag);
        int db, cpb, sb, f;
        logic [127:0] l0 = '1, b0 = '0, dn0 = '0, r0 = '0, l1 = '1;
        logic [127:0] eb = '0, edn = '0, er = '0;
        db  = (grp == 0) ? DB_A : DB_B;
        cpb = (grp == 0) ? CPB_A : CPB_B;
        sb  = (grp == 0) ? SB_A : SB_B;
        f   = (1 + db + P_EN + sb) * cpb;
        if (!preloaded) begin
            @(negedge clk);
            drive(grp, d, 1'b1);
        end
        @(posedge clk);
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            if (grp == 0) begin
                l0[k] = line_a; b0[k] = busy_a; dn0[k] = done_a; r0[k] = rdy_a;
                l1[k] = line_o;
            end else begin
                l0[k] = line_b; b0[k] = busy_b; dn0[k] = done_b; r0[k] = rdy_b;
            end
            if (k <= f) begin
                if (noise) drive(grp, 9'($urandom), 1'($urandom));
                else if (chain) drive(grp, (k == 2) ? ~d : ((grp == 0) ? {1'b0, din_a} : din_b), 1'b1);
                else drive(grp, d, 1'b0);
            end else begin
                drive(grp, chain ? next_d : d, chain);
            end
        end
        for (int k = 1; k <= f; k++) eb[k] = 1'b1;
        edn[f + 1] = 1'b1;
        er[f + 1]  = 1'b1;
        check({tag, " line"},  l0, model_line(db, cpb, sb, d, par_even));
        check({tag, " busy"},  b0, eb);
        check({tag, " done"},  dn0, edn);
        check({tag, " ready"}, r0, er);
        check({tag, " length"}, 128'($countones(b0)), 128'(exp_cycles));
        if (grp == 0) check({tag, " line odd"}, l1, model_line(db, cpb, sb, d, ~par_even));
    endtask

    typedef struct {
        int         grp;
        logic [8:0] data;
        logic       par_even;
        int         cycles;
        bit         noise;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[$];
        logic [8:0] d;
        int grp;

        vecs.push_back('{0, 9'h0A5, 1'b0, (P_EN != 0) ? 44 : 40, 1'b0});
        vecs.push_back('{0, 9'h007, 1'b1, (P_EN != 0) ? 44 : 40, 1'b0});
        vecs.push_back('{0, 9'h000, 1'b0, (P_EN != 0) ? 44 : 40, 1'b0});
        vecs.push_back('{0, 9'h0FF, 1'b0, (P_EN != 0) ? 44 : 40, 1'b1});
        vecs.push_back('{0, 9'h080, 1'b1, (P_EN != 0) ? 44 : 40, 1'b1});
        vecs.push_back('{1, 9'h1FF, 1'b1, (P_EN != 0) ? 27 : 24, 1'b0});
        vecs.push_back('{1, 9'h00A, 1'b0, (P_EN != 0) ? 27 : 24, 1'b1});
        vecs.push_back('{1, 9'h0F5, 1'b1, (P_EN != 0) ? 27 : 24, 1'b0});

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset a", {line_a, rdy_a, busy_a, done_a}, 4'b1100);
        check("reset o", {line_o, rdy_o, busy_o, done_o}, 4'b1100);
        check("reset b", {line_b, rdy_b, busy_b, done_b}, 4'b1100);
        reset = 1'b0;

        foreach (vecs[i])
            run_frame(vecs[i].grp, vecs[i].data, vecs[i].par_even, vecs[i].cycles,
                      vecs[i].noise, 1'b0, 9'h0, 1'b0, $sformatf("vec%0d", i));

        // Back-to-back with data_valid held: second start bit F+1 cycles after the first.
        run_frame(0, 9'h055, 1'b0, (P_EN != 0) ? 44 : 40, 1'b0, 1'b1, 9'h00F, 1'b0, "b2b first");
        run_frame(0, 9'h00F, 1'b0, (P_EN != 0) ? 44 : 40, 1'b0, 1'b0, 9'h000, 1'b1, "b2b second");

        for (int i = 0; i < 16; i++) begin
            grp = i % 2;
            d = (grp == 0) ? 9'($urandom_range(0, 255)) : 9'($urandom_range(0, 31));
            run_frame(grp, d, ^d, (grp == 0) ? ((P_EN != 0) ? 44 : 40) : ((P_EN != 0) ? 27 : 24),
                      1'($urandom), 1'b0, 9'h0, 1'b0, $sformatf("rand%0d", i));
        end

        // Reset in the middle of DATA, together with data_valid: frame abandoned, nothing accepted.
        @(negedge clk);
        drive(0, 9'h000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 9'h000, 1'b0);
        repeat (CPB_A + 2) @(negedge clk);
        check("mid data line low", {line_a, busy_a}, 2'b01);
        reset = 1'b1;
        drive(0, 9'h0FF, 1'b1);
        @(negedge clk);
        check("mid reset a", {line_a, rdy_a, busy_a, done_a}, 4'b1100);
        reset = 1'b0;
        drive(0, 9'h0FF, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("after reset %0d", k), {line_a, rdy_a, busy_a, done_a}, 4'b1100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
